// File: rtl/gyruss_hpf_if.sv
// Audio sample bus between the mixer and the high-pass stage.
// The filter owns out/out_stb; the source drives in.
interface gyruss_hpf_if;
  logic signed [15:0] in;
  logic signed [15:0] out;
  logic               out_stb;

  modport master (output in, input out, input out_stb);
  modport slave  (input in, output out, output out_stb);
endinterface

// File: rtl/gyruss_hpf.sv
// First-order DC-blocking IIR high-pass: y[n] = x[n] - x[n-1] + a*y[n-1].
// One sample per DIV clocks; out/out_stb register 4 clocks after the divider tick.
module gyruss_hpf #(
  parameter int DIV    = 220,
  parameter int A_COEF = 32604
) (
  input  logic        clk,
  input  logic        reset,
  gyruss_hpf_if.slave aud
);

  localparam logic signed [17:0] A       = 18'(A_COEF);
  localparam logic        [9:0]  CNT_MAX = 10'(DIV - 1);

  typedef enum logic [2:0] {IDLE, DIFF, MUL, SUM, OUT} state_t;

  state_t             state, state_nx;
  logic        [9:0]  cnt;
  logic               tick;
  logic               ld_diff, ld_prod, ld_s, ld_out;

  logic signed [15:0] x_prev;
  logic signed [16:0] diff;
  logic signed [31:0] prod;
  logic signed [31:0] s;
  logic signed [15:0] out_q;
  logic               out_stb_q;

  logic signed [16:0] diff_w;
  logic signed [49:0] prod_full;
  logic signed [33:0] sum_w;
  logic signed [31:0] s_sat;
  logic signed [16:0] s_hi;
  logic signed [15:0] out_sat;
  logic               prod_unused;

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 10'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tick) state_nx = DIFF;
      DIFF:    state_nx = MUL;
      MUL:     state_nx = SUM;
      SUM:     state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ld_diff = 1'b0;
    ld_prod = 1'b0;
    ld_s    = 1'b0;
    ld_out  = 1'b0;
    case (state)
      DIFF:    ld_diff = 1'b1;
      MUL:     ld_prod = 1'b1;
      SUM:     ld_s    = 1'b1;
      OUT:     ld_out  = 1'b1;
      default: ;
    endcase
  end

  // 17-bit difference of two 16-bit samples cannot overflow.
  always_comb begin
    diff_w    = {aud.in[15], aud.in} - {x_prev[15], x_prev};
    prod_full = A * s;
    sum_w     = {diff[16], diff[16], diff, 15'd0} + {{2{prod[31]}}, prod};

    if (sum_w > 34'sd2147483647)       s_sat = 32'sh7fff_ffff;
    else if (sum_w < -34'sd2147483648) s_sat = 32'sh8000_0000;
    else                               s_sat = sum_w[31:0];

    s_hi = s[31:15];
    if (s_hi > 17'sd32767)       out_sat = 16'sh7fff;
    else if (s_hi < -17'sd32768) out_sat = 16'sh8000;
    else                         out_sat = s_hi[15:0];

    // Bits outside the Q15-aligned 32-bit window are intentionally dropped.
    prod_unused = ^{prod_full[49:47], prod_full[14:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_prev    <= '0;
      diff      <= '0;
      prod      <= '0;
      s         <= '0;
      out_q     <= '0;
      out_stb_q <= 1'b0;
    end else begin
      if (ld_diff) begin
        diff   <= diff_w;
        x_prev <= aud.in;
      end
      if (ld_prod) prod  <= prod_full[46:15];
      if (ld_s)    s     <= s_sat;
      if (ld_out)  out_q <= out_sat;
      out_stb_q <= ld_out;
    end
  end

  assign aud.out     = out_q;
  assign aud.out_stb = out_stb_q;

endmodule
